l1_mem_arbiter: RTL and testbench

- Arbitrates instruction-cache and data-cache miss/refill/write traffic onto one external memory port.
- Sits directly downstream of the L1 caches: the I-side port takes L1C_inst I_req/I_addr/I_out/I_wait; the D-side port takes L1C_data D_req/D_addr/D_write/D_in/D_out/D_wait.
- One transaction is outstanding at a time. The external port uses a valid/ready address phase and an rvalid response phase.

---
 rtl/l1_mem_arbiter.sv | 124 ++++++++++++
 tb/tb_l1_mem_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_mem_arbiter.sv
// rtl/l1_mem_arbiter.sv - I/D L1 miss, refill and write arbiter onto one external memory port
//
// Ports:
//   clk, resetb                 core clock, asynchronous active-low reset
//   i_req/i_addr                I-cache read request (held until i_wait low)
//   i_rdata/i_wait              I-cache read data and stall
//   d_req/d_write/d_addr        D-cache request, direction and address (held until d_wait low)
//   d_wdata/d_wstrb             D-cache write data and byte strobes
//   d_rdata/d_wait              D-cache read data and stall
//   m_valid/m_ready             memory command handshake
//   m_write/m_addr/m_wdata/m_wstrb  memory command fields (stable while m_valid)
//   m_rvalid/m_rdata            memory response (read data or write ack)
module l1_mem_arbiter #(
   parameter bit FAIR      = 1'b1,
   parameter bit WR_POSTED = 1'b0
) (
   input  logic        clk,
   input  logic        resetb,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_wait,
   input  logic        d_req,
   input  logic        d_write,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic [31:0] d_rdata,
   output logic        d_wait,
   output logic        m_valid,
   input  logic        m_ready,
   output logic        m_write,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb,
   input  logic        m_rvalid,
   input  logic [31:0] m_rdata
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   logic [1:0]  state;
   logic        owner;
   logic        last_owner;
   logic        grant_d;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;

   // On a tie, fair mode hands the port to whichever side did not own it last.
   always_comb begin
      grant_d = d_req;
      if (i_req && d_req) begin
         grant_d = FAIR ? (last_owner == OWN_I) : 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state      <= ST_IDLE;
         owner      <= OWN_D;
         last_owner <= OWN_D;
         cmd_write  <= 1'b0;
         cmd_addr   <= 32'd0;
         cmd_wdata  <= 32'd0;
         cmd_wstrb  <= 4'd0;
         i_rdata    <= 32'd0;
         d_rdata    <= 32'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_req || d_req) begin
                  owner      <= grant_d;
                  last_owner <= grant_d;
                  cmd_addr   <= grant_d ? d_addr : i_addr;
                  cmd_write  <= grant_d && d_write;
                  cmd_wdata  <= grant_d ? d_wdata : 32'd0;
                  cmd_wstrb  <= (grant_d && d_write) ? d_wstrb : 4'd0;
                  state      <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               // m_rvalid here is a protocol error and is deliberately ignored.
               if (m_ready) begin
                  state <= (cmd_write && WR_POSTED) ? ST_RESP : ST_DATA;
               end
            end
            ST_DATA: begin
               if (m_rvalid) begin
                  if (!cmd_write) begin
                     if (owner == OWN_D) begin
                        d_rdata <= m_rdata;
                     end else begin
                        i_rdata <= m_rdata;
                     end
                  end
                  state <= ST_RESP;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign m_valid = (state == ST_ADDR);
   assign m_write = cmd_write;
   assign m_addr  = cmd_addr;
   assign m_wdata = cmd_wdata;
   assign m_wstrb = cmd_wstrb;

   // A side whose req was dropped mid-transaction sees wait=0 simply because req is low.
   assign i_wait = i_req && !((state == ST_RESP) && (owner == OWN_I));
   assign d_wait = d_req && !((state == ST_RESP) && (owner == OWN_D));

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// tb/tb_l1_mem_arbiter.sv - bench for l1_mem_arbiter (u0: FAIR=1 non-posted, u1: FAIR=0 posted)
module tb_l1_mem_arbiter;

   logic        clk = 1'b0;
   logic        resetb = 1'b0;

   logic        i_req   [2];
   logic [31:0] i_addr  [2];
   logic [31:0] i_rdata [2];
   logic        i_wait  [2];
   logic        d_req   [2];
   logic        d_write [2];
   logic [31:0] d_addr  [2];
   logic [31:0] d_wdata [2];
   logic [3:0]  d_wstrb [2];
   logic [31:0] d_rdata [2];
   logic        d_wait  [2];
   logic        m_valid [2];
   logic        m_ready [2];
   logic        m_write [2];
   logic [31:0] m_addr  [2];
   logic [31:0] m_wdata [2];
   logic [3:0]  m_wstrb [2];
   logic        m_rvalid[2];
   logic [31:0] m_rdata [2];

   int npass = 0;
   int ntot  = 0;

   always #5 clk = ~clk;

   l1_mem_arbiter #(.FAIR(1'b1), .WR_POSTED(1'b0)) u0 (
      .clk(clk), .resetb(resetb),
      .i_req(i_req[0]), .i_addr(i_addr[0]), .i_rdata(i_rdata[0]), .i_wait(i_wait[0]),
      .d_req(d_req[0]), .d_write(d_write[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
      .d_wstrb(d_wstrb[0]), .d_rdata(d_rdata[0]), .d_wait(d_wait[0]),
      .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_write(m_write[0]), .m_addr(m_addr[0]),
      .m_wdata(m_wdata[0]), .m_wstrb(m_wstrb[0]), .m_rvalid(m_rvalid[0]), .m_rdata(m_rdata[0])
   );

   l1_mem_arbiter #(.FAIR(1'b0), .WR_POSTED(1'b1)) u1 (
      .clk(clk), .resetb(resetb),
      .i_req(i_req[1]), .i_addr(i_addr[1]), .i_rdata(i_rdata[1]), .i_wait(i_wait[1]),
      .d_req(d_req[1]), .d_write(d_write[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
      .d_wstrb(d_wstrb[1]), .d_rdata(d_rdata[1]), .d_wait(d_wait[1]),
      .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_write(m_write[1]), .m_addr(m_addr[1]),
      .m_wdata(m_wdata[1]), .m_wstrb(m_wstrb[1]), .m_rvalid(m_rvalid[1]), .m_rdata(m_rdata[1])
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      for (int k = 0; k < 2; k++) begin
         i_req[k] = 1'b0;   i_addr[k] = 32'd0;
         d_req[k] = 1'b0;   d_write[k] = 1'b0;  d_addr[k] = 32'd0;
         d_wdata[k] = 32'd0; d_wstrb[k] = 4'd0;
         m_ready[k] = 1'b0; m_rvalid[k] = 1'b0; m_rdata[k] = 32'd0;
      end
   endtask

   // Leaves time at posedge+3 in an IDLE cycle, ready for inputs.
   task automatic do_reset();
      clear_inputs();
      resetb = 1'b0;
      @(posedge clk);
      #3;
      resetb = 1'b1;
   endtask

   // Called in an IDLE cycle with requests already driven; returns settled in the RESP cycle.
   task automatic mem_txn(input int k, input logic [31:0] ea, input logic ew,
                          input logic [31:0] rd, input logic posted);
      #1;
      chk1("txn_idle_m_valid", m_valid[k], 1'b0);
      tick();
      m_ready[k] = 1'b1;
      #1;
      chk1("txn_m_valid", m_valid[k], 1'b1);
      chk32("txn_m_addr", m_addr[k], ea);
      chk1("txn_m_write", m_write[k], ew);
      tick();
      m_ready[k] = 1'b0;
      if (!(ew && posted)) begin
         m_rvalid[k] = 1'b1;
         m_rdata[k]  = rd;
         #1;
         chk1("txn_data_m_valid", m_valid[k], 1'b0);
         tick();
         m_rvalid[k] = 1'b0;
      end
      #1;
   endtask

   task automatic rand_run(input int k, input int ncyc);
      int          ph;     // 0 free, 1 awaiting accept, 2 awaiting response, 3 completion cycle
      logic        own;    // 1 = D side owns the transaction
      logic        last;
      logic        fair;
      logic        posted;
      logic [31:0] ea, ewd, eir, edr;
      logic        ew;
      logic [3:0]  es;
      fair = (k == 0);
      posted = (k == 1);
      ph = 0; own = 1'b1; last = 1'b1;
      ea = 32'd0; ewd = 32'd0; eir = 32'd0; edr = 32'd0; ew = 1'b0; es = 4'd0;
      do_reset();
      for (int c = 0; c < ncyc; c++) begin
         if (!i_req[k] && $urandom_range(0, 2) == 0) begin
            i_req[k]  = 1'b1;
            i_addr[k] = $urandom;
         end
         if (!d_req[k] && $urandom_range(0, 2) == 0) begin
            d_req[k]   = 1'b1;
            d_write[k] = 1'($urandom_range(0, 1));
            d_addr[k]  = $urandom;
            d_wdata[k] = $urandom;
            d_wstrb[k] = 4'($urandom);
         end
         m_ready[k]  = ($urandom_range(0, 3) != 0);
         m_rvalid[k] = ($urandom_range(0, 2) == 0);
         m_rdata[k]  = $urandom;
         #1;
         chk1("rnd_i_wait", i_wait[k], i_req[k] && !(ph == 3 && !own));
         chk1("rnd_d_wait", d_wait[k], d_req[k] && !(ph == 3 && own));
         chk1("rnd_m_valid", m_valid[k], ph == 1);
         chk32("rnd_i_rdata", i_rdata[k], eir);
         chk32("rnd_d_rdata", d_rdata[k], edr);
         if (ph == 1) begin
            chk32("rnd_m_addr", m_addr[k], ea);
            chk1("rnd_m_write", m_write[k], ew);
            chk32("rnd_m_wstrb", {28'd0, m_wstrb[k]}, {28'd0, es});
            if (ew) chk32("rnd_m_wdata", m_wdata[k], ewd);
         end
         case (ph)
            0: begin
               if (i_req[k] || d_req[k]) begin
                  if (i_req[k] && d_req[k]) own = fair ? !last : 1'b1;
                  else own = d_req[k];
                  last = own;
                  if (own) begin
                     ea = d_addr[k]; ew = d_write[k]; ewd = d_wdata[k];
                     es = d_write[k] ? d_wstrb[k] : 4'd0;
                  end else begin
                     ea = i_addr[k]; ew = 1'b0; ewd = 32'd0; es = 4'd0;
                  end
                  ph = 1;
               end
            end
            1: if (m_ready[k]) ph = (ew && posted) ? 3 : 2;
            2: begin
               if (m_rvalid[k]) begin
                  if (!ew) begin
                     if (own) edr = m_rdata[k];
                     else eir = m_rdata[k];
                  end
                  ph = 3;
               end
            end
            default: begin
               ph = 0;
               if (own) d_req[k] = 1'b0;
               else i_req[k] = 1'b0;
            end
         endcase
         tick();
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      resetb = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk1("rst_m_valid", m_valid[0], 1'b0);
      chk1("rst_m_write", m_write[0], 1'b0);
      chk32("rst_m_addr", m_addr[0], 32'd0);
      chk32("rst_m_wdata", m_wdata[0], 32'd0);
      chk32("rst_m_wstrb", {28'd0, m_wstrb[0]}, 32'd0);
      chk32("rst_i_rdata", i_rdata[0], 32'd0);
      chk32("rst_d_rdata", d_rdata[0], 32'd0);
      chk1("rst_i_wait", i_wait[0], 1'b0);
      chk1("rst_d_wait", d_wait[0], 1'b0);
      resetb = 1'b1;
      tick();

      // Single I read, minimum latency
      i_req[0] = 1'b1; i_addr[0] = 32'h0000_0100;
      #1;
      chk1("t1_c0_i_wait", i_wait[0], 1'b1);
      chk1("t1_c0_m_valid", m_valid[0], 1'b0);
      tick();
      m_ready[0] = 1'b1;
      #1;
      chk1("t1_c1_m_valid", m_valid[0], 1'b1);
      chk32("t1_c1_m_addr", m_addr[0], 32'h0000_0100);
      chk1("t1_c1_m_write", m_write[0], 1'b0);
      chk32("t1_c1_m_wstrb", {28'd0, m_wstrb[0]}, 32'd0);
      chk1("t1_c1_i_wait", i_wait[0], 1'b1);
      tick();
      m_ready[0] = 1'b0; m_rvalid[0] = 1'b1; m_rdata[0] = 32'hDEAD_BEEF;
      #1;
      chk1("t1_c2_m_valid", m_valid[0], 1'b0);
      chk1("t1_c2_i_wait", i_wait[0], 1'b1);
      tick();
      m_rvalid[0] = 1'b0;
      #1;
      chk1("t1_c3_i_wait", i_wait[0], 1'b0);
      chk32("t1_c3_i_rdata", i_rdata[0], 32'hDEAD_BEEF);
      i_req[0] = 1'b0;
      tick();
      #1;
      chk1("t1_c4_i_wait", i_wait[0], 1'b0);
      chk1("t1_c4_m_valid", m_valid[0], 1'b0);

      // Fair round-robin after reset: I, D, I
      do_reset();
      i_req[0] = 1'b1; i_addr[0] = 32'h0000_1000;
      d_req[0] = 1'b1; d_addr[0] = 32'h0000_2000;
      mem_txn(0, 32'h0000_1000, 1'b0, 32'hA000_0001, 1'b0);
      chk1("rr1_i_wait", i_wait[0], 1'b0);
      chk1("rr1_d_wait", d_wait[0], 1'b1);
      chk32("rr1_i_rdata", i_rdata[0], 32'hA000_0001);
      tick();
      mem_txn(0, 32'h0000_2000, 1'b0, 32'hB000_0002, 1'b0);
      chk1("rr2_d_wait", d_wait[0], 1'b0);
      chk1("rr2_i_wait", i_wait[0], 1'b1);
      chk32("rr2_d_rdata", d_rdata[0], 32'hB000_0002);
      tick();
      mem_txn(0, 32'h0000_1000, 1'b0, 32'hC000_0003, 1'b0);
      chk1("rr3_i_wait", i_wait[0], 1'b0);
      chk1("rr3_d_wait", d_wait[0], 1'b1);
      clear_inputs();
      tick();

      // Fixed priority: D wins every time
      do_reset();
      i_req[1] = 1'b1; i_addr[1] = 32'h0000_1000;
      d_req[1] = 1'b1; d_addr[1] = 32'h0000_2000;
      for (int r = 0; r < 3; r++) begin
         mem_txn(1, 32'h0000_2000, 1'b0, 32'hD000_0000 + 32'(r), 1'b1);
         chk1("fp_d_wait", d_wait[1], 1'b0);
         chk1("fp_i_wait", i_wait[1], 1'b1);
         chk32("fp_d_rdata", d_rdata[1], 32'hD000_0000 + 32'(r));
         tick();
      end
      clear_inputs();
      tick();

      // Non-posted D write with a 3-cycle accept stall
      d_req[0] = 1'b1; d_write[0] = 1'b1; d_addr[0] = 32'h2000_0010;
      d_wdata[0] = 32'h1234_5678; d_wstrb[0] = 4'b0011;
      #1;
      chk1("wr_idle_d_wait", d_wait[0], 1'b1);
      tick();
      for (int s = 0; s < 4; s++) begin
         m_ready[0] = (s == 3);
         #1;
         chk1("wr_stall_m_valid", m_valid[0], 1'b1);
         chk1("wr_stall_m_write", m_write[0], 1'b1);
         chk32("wr_stall_m_addr", m_addr[0], 32'h2000_0010);
         chk32("wr_stall_m_wdata", m_wdata[0], 32'h1234_5678);
         chk32("wr_stall_m_wstrb", {28'd0, m_wstrb[0]}, 32'h3);
         chk1("wr_stall_d_wait", d_wait[0], 1'b1);
         tick();
      end
      m_ready[0] = 1'b0;
      #1;
      chk1("wr_data_m_valid", m_valid[0], 1'b0);
      chk1("wr_data_d_wait", d_wait[0], 1'b1);
      tick();
      m_rvalid[0] = 1'b1; m_rdata[0] = 32'hBAD0_BAD0;
      #1;
      chk1("wr_rv_d_wait", d_wait[0], 1'b1);
      tick();
      m_rvalid[0] = 1'b0;
      #1;
      chk1("wr_resp_d_wait", d_wait[0], 1'b0);
      chk32("wr_resp_d_rdata", d_rdata[0], 32'd0);
      d_req[0] = 1'b0;
      tick();

      // Posted D write, then a stray response while idle
      d_req[1] = 1'b1; d_write[1] = 1'b1; d_addr[1] = 32'h3000_0020;
      d_wdata[1] = 32'hCAFE_F00D; d_wstrb[1] = 4'b1100;
      tick();
      m_ready[1] = 1'b1;
      #1;
      chk1("pw_m_valid", m_valid[1], 1'b1);
      chk32("pw_m_wstrb", {28'd0, m_wstrb[1]}, 32'hC);
      chk1("pw_addr_d_wait", d_wait[1], 1'b1);
      tick();
      m_ready[1] = 1'b0;
      #1;
      chk1("pw_resp_d_wait", d_wait[1], 1'b0);
      chk1("pw_resp_m_valid", m_valid[1], 1'b0);
      d_req[1] = 1'b0;
      tick();
      m_rvalid[1] = 1'b1; m_rdata[1] = 32'hFFFF_0000;
      tick();
      m_rvalid[1] = 1'b0;
      #1;
      chk32("pw_stray_d_rdata", d_rdata[1], 32'hD000_0002);
      chk32("pw_stray_i_rdata", i_rdata[1], 32'd0);
      chk1("pw_stray_m_valid", m_valid[1], 1'b0);
      tick();

      // Asynchronous reset while waiting for the read response
      i_req[0] = 1'b1; i_addr[0] = 32'h0000_0300;
      tick();
      m_ready[0] = 1'b1;
      tick();
      m_ready[0] = 1'b0;
      #1;
      chk1("ar_data_m_valid", m_valid[0], 1'b0);
      chk32("ar_data_m_addr", m_addr[0], 32'h0000_0300);
      resetb = 1'b0;
      #1;
      chk1("ar_m_valid", m_valid[0], 1'b0);
      chk32("ar_m_addr", m_addr[0], 32'd0);
      chk1("ar_i_wait", i_wait[0], 1'b1);
      chk1("ar_d_wait", d_wait[0], 1'b0);
      i_req[0] = 1'b0;
      tick();
      resetb = 1'b1;
      m_rvalid[0] = 1'b1; m_rdata[0] = 32'h5555_AAAA;
      #1;
      tick();
      m_rvalid[0] = 1'b0;
      #1;
      chk32("ar_stale_i_rdata", i_rdata[0], 32'd0);
      chk1("ar_stale_m_valid", m_valid[0], 1'b0);
      chk1("ar_stale_i_wait", i_wait[0], 1'b0);
      tick();

      // I drops its request during DATA; pending D is served next
      i_req[0] = 1'b1; i_addr[0] = 32'h0000_0400;
      d_req[0] = 1'b1; d_write[0] = 1'b0; d_addr[0] = 32'h0000_0500;
      #1;
      chk1("dr_idle_i_wait", i_wait[0], 1'b1);
      chk1("dr_idle_d_wait", d_wait[0], 1'b1);
      tick();
      m_ready[0] = 1'b1;
      #1;
      chk32("dr_m_addr_i", m_addr[0], 32'h0000_0400);
      tick();
      m_ready[0] = 1'b0; i_req[0] = 1'b0;
      m_rvalid[0] = 1'b1; m_rdata[0] = 32'h0000_0077;
      #1;
      chk1("dr_data_i_wait", i_wait[0], 1'b0);
      chk1("dr_data_d_wait", d_wait[0], 1'b1);
      tick();
      m_rvalid[0] = 1'b0;
      #1;
      chk1("dr_resp_d_wait", d_wait[0], 1'b1);
      chk1("dr_resp_m_valid", m_valid[0], 1'b0);
      tick();
      mem_txn(0, 32'h0000_0500, 1'b0, 32'h0000_0088, 1'b0);
      chk1("dr_d_done_wait", d_wait[0], 1'b0);
      chk32("dr_d_rdata", d_rdata[0], 32'h0000_0088);
      d_req[0] = 1'b0;
      tick();

      // Randomized traffic against the transaction-level model
      rand_run(0, 1500);
      rand_run(1, 1500);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
